// File: rtl/data_axi_bridge_pkg.sv
// Shared types and AXI constants for the data-side SRAM-like to AXI4 bridge.
package data_axi_bridge_pkg;

  // Bridge FSM encoding. Kept as plain constants so older tools and
  // waveform viewers see stable numeric values.
  typedef logic [2:0] bridge_state_t;

  localparam bridge_state_t ST_IDLE    = 3'd0;
  localparam bridge_state_t ST_RD_ADDR = 3'd1;
  localparam bridge_state_t ST_RD_DATA = 3'd2;
  localparam bridge_state_t ST_WR_REQ  = 3'd3;
  localparam bridge_state_t ST_WR_RESP = 3'd4;

  // Only single-beat INCR transfers are ever issued.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // Convert the 2-bit request size (0 byte, 1 half, 2 word) to AXSIZE.
  function automatic logic [2:0] axi_size(input logic [1:0] req_size);
    return {1'b0, req_size};
  endfunction

endpackage

// File: rtl/data_axi_bridge_wr_pair.sv
// Tracks independent completion of the AW and W handshakes of one store.
// AW and W are offered together; each valid drops only after its own
// handshake, and done_o reports both complete, including same-cycle ones.
module axi_wr_pair
  import data_axi_bridge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear_i,    // a new store is being accepted
  input  logic active_i,   // bridge is in the write-request phase
  input  logic awready_i,
  input  logic wready_i,
  output logic awvalid_o,
  output logic wvalid_o,
  output logic done_o
);

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic aw_hs, w_hs;

  assign awvalid_o = active_i && !aw_done_q;
  assign wvalid_o  = active_i && !w_done_q;
  assign aw_hs     = awvalid_o && awready_i;
  assign w_hs      = wvalid_o && wready_i;
  assign done_o    = active_i && (aw_done_q || aw_hs) && (w_done_q || w_hs);

  // Next-state for the two done flags: clear on a new store, set on handshake.
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (clear_i) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_hs) aw_done_d = 1'b1;
      if (w_hs)  w_done_d  = 1'b1;
    end
  end

  // Done-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: rtl/data_axi_bridge.sv
// Data-side bridge: SRAM-like req/addr_ok/data_ok port to a single-beat AXI4
// master. Exactly one transaction is outstanding, so loads and stores leave
// in program order. All AXI outputs derive from state and latched fields.
//
// Handshake semantics: an AXI channel transfers on a cycle where valid and
// ready are both high; a valid, once raised, holds with stable payload until
// that cycle. On the request side, addr_ok is the acceptance strobe for req
// and data_ok pulses once per accepted request with no back-pressure.
module data_axi_bridge
  import data_axi_bridge_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata_axi,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata_axi,
  output logic [3:0]  wstrb_axi,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  bridge_state_t state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [1:0]    size_q, size_d;

  logic in_idle, in_rd_addr, in_rd_data, in_wr_req, in_wr_resp;
  logic accept, wr_clear, wr_done;

  // Response ID/status fields are not used: no error path exists.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  assign in_idle    = (state_q == ST_IDLE);
  assign in_rd_addr = (state_q == ST_RD_ADDR);
  assign in_rd_data = (state_q == ST_RD_DATA);
  assign in_wr_req  = (state_q == ST_WR_REQ);
  assign in_wr_resp = (state_q == ST_WR_RESP);

  // A request is only taken in IDLE; holding req elsewhere does nothing.
  assign accept   = in_idle && req && !reset;
  assign wr_clear = accept && we;
  assign addr_ok  = accept;

  axi_wr_pair u_wr_pair (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (wr_clear),
    .active_i  (in_wr_req),
    .awready_i (awready),
    .wready_i  (wready),
    .awvalid_o (awvalid),
    .wvalid_o  (wvalid),
    .done_o    (wr_done)
  );

  // Read address / data channel.
  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = axi_size(size_q);
  assign arburst = AXI_BURST_INCR;
  assign arvalid = in_rd_addr;
  assign rready  = in_rd_data;

  // Write address / data / response channel.
  assign awid      = WR_ID;
  assign awaddr    = addr_q;
  assign awlen     = AXI_LEN_SINGLE;
  assign awsize    = axi_size(size_q);
  assign awburst   = AXI_BURST_INCR;
  assign wid       = WR_ID;
  assign wdata_axi = wdata_q;
  assign wstrb_axi = wstrb_q;
  assign wlast     = 1'b1;
  assign bready    = in_wr_resp;

  // Completion is signalled in the same cycle as the R or B handshake.
  assign data_ok = (in_rd_data && rvalid) || (in_wr_resp && bvalid);
  assign rdata   = (in_rd_data && rvalid) ? rdata_axi : 32'd0;

  // FSM next-state and request-field latching.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    size_d  = size_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          size_d  = size;
          state_d = we ? ST_WR_REQ : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (arready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (rvalid)  state_d = ST_IDLE;
      ST_WR_REQ:  if (wr_done) state_d = ST_WR_RESP;
      ST_WR_RESP: if (bvalid)  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      size_q  <= size_d;
    end
  end

endmodule
